// File: rtl/nco_clk_recovery_if.sv
// Bus between the timing-error detector and the clock-recovery NCO.
// Handshake: err_data is consumed on every cycle err_valid is high; there is no ready, the NCO always accepts.
interface nco_clk_recovery_if #(
    parameter int ERR_W = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 10
);
    logic [ACC_W-1:0]        fcw_init;
    logic                    err_valid;
    logic signed [ERR_W-1:0] err_data;
    logic [OUT_W-1:0]        phase_out;
    logic                    clk_out;
    logic                    upd_strobe;
    logic                    locked;
    logic                    sat;

    modport master (
        output fcw_init, err_valid, err_data,
        input  phase_out, clk_out, upd_strobe, locked, sat
    );

    modport slave (
        input  fcw_init, err_valid, err_data,
        output phase_out, clk_out, upd_strobe, locked, sat
    );
endinterface

// File: rtl/nco_clk_recovery.sv
// Clock-recovery NCO: PI loop filter on a signed timing-error stream driving a wrapping
// phase accumulator; produces recovered clock, phase word, update strobe and lock flag.
module nco_clk_recovery #(
    parameter int ERR_W    = 16,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 10,
    parameter int UPD_LOG2 = 5,
    parameter int KP_SH    = 3,
    parameter int LOCK_THR = 64,
    parameter int LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    nco_clk_recovery_if.slave bus
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(LOCK_THR);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;
    localparam int                      LC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [LC_W-1:0]         LC_MAX  = LC_W'(LOCK_CNT);

    // Returns {overflow_flag, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    logic [UPD_LOG2-1:0]     cnt;
    logic signed [ACC_W-1:0] int_acc;
    logic signed [ACC_W-1:0] prop_acc;
    logic signed [ACC_W-1:0] win_sum;
    logic signed [ACC_W-1:0] freq_adj;
    logic signed [ACC_W-1:0] phase_jump;
    logic [ACC_W-1:0]        phase_acc;
    logic [LC_W-1:0]         lock_cnt;
    logic                    clk_out_r;
    logic                    upd_strobe_r;
    logic                    locked_r;
    logic                    sat_r;

    logic signed [ACC_W-1:0] e;
    logic signed [ACC_W-1:0] e_sh;
    logic [ACC_W:0]          r_int;
    logic [ACC_W:0]          r_prop;
    logic [ACC_W:0]          r_win;
    logic signed [ACC_W-1:0] int_next;
    logic signed [ACC_W-1:0] prop_next;
    logic signed [ACC_W-1:0] win_next;
    logic                    sat_hit;
    logic                    upd;
    logic                    win_in;
    logic [LC_W-1:0]         lock_next;
    logic [ACC_W-1:0]        jump_add;

    assign e    = {{(ACC_W-ERR_W){bus.err_data[ERR_W-1]}}, bus.err_data};
    assign e_sh = e << KP_SH;
    assign upd  = &cnt;

    // A sample arriving on the update cycle is folded in here so the transfer sees it.
    always_comb begin
        r_int  = {1'b0, int_acc};
        r_prop = {1'b0, prop_acc};
        r_win  = {1'b0, win_sum};
        if (bus.err_valid) begin
            r_int  = sat_add(int_acc, e);
            r_prop = sat_add(prop_acc, e_sh);
            r_win  = sat_add(win_sum, e);
        end
    end

    assign int_next  = r_int[ACC_W-1:0];
    assign prop_next = r_prop[ACC_W-1:0];
    assign win_next  = r_win[ACC_W-1:0];
    assign sat_hit   = r_int[ACC_W] | r_prop[ACC_W] | r_win[ACC_W];
    assign win_in    = (win_next < THR_P) && (win_next > THR_N);
    assign jump_add  = upd_strobe_r ? phase_jump : '0;

    always_comb begin
        lock_next = '0;
        if (win_in) begin
            lock_next = (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + LC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            int_acc      <= '0;
            prop_acc     <= '0;
            win_sum      <= '0;
            freq_adj     <= '0;
            phase_jump   <= '0;
            phase_acc    <= '0;
            lock_cnt     <= '0;
            clk_out_r    <= 1'b0;
            upd_strobe_r <= 1'b0;
            locked_r     <= 1'b0;
            sat_r        <= 1'b0;
        end else begin
            cnt          <= cnt + UPD_LOG2'(1);
            int_acc      <= int_next;
            upd_strobe_r <= upd;
            clk_out_r    <= ~phase_acc[ACC_W-1];
            phase_acc    <= phase_acc + bus.fcw_init + freq_adj + jump_add;
            if (sat_hit) begin
                sat_r <= 1'b1;
            end
            // The jump is consumed once, in the strobe cycle; updates never coincide with it.
            if (upd_strobe_r) begin
                phase_jump <= '0;
            end
            if (upd) begin
                freq_adj   <= int_next;
                phase_jump <= prop_next;
                prop_acc   <= '0;
                win_sum    <= '0;
                lock_cnt   <= lock_next;
                locked_r   <= (lock_next == LC_MAX);
            end else begin
                prop_acc <= prop_next;
                win_sum  <= win_next;
            end
        end
    end

    assign bus.phase_out  = phase_acc[ACC_W-1 -: OUT_W];
    assign bus.clk_out    = clk_out_r;
    assign bus.upd_strobe = upd_strobe_r;
    assign bus.locked     = locked_r;
    assign bus.sat        = sat_r;
endmodule

// File: tb/tb_nco_clk_recovery.sv
// Bench for nco_clk_recovery: window-level reference model, table of loop-filter windows,
// hand sequences for lock, reset and saturation corners, and randomized error streams.
`timescale 1ns/1ps
module tb_nco_clk_recovery;
    localparam int OUT_W = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    nco_clk_recovery_if #(.ERR_W(16), .ACC_W(32), .OUT_W(OUT_W)) ifa ();
    nco_clk_recovery_if #(.ERR_W(16), .ACC_W(20), .OUT_W(OUT_W)) ifb ();

    nco_clk_recovery dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    nco_clk_recovery #(.ACC_W(20)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (window level) ----------------
    int           m_cnt;
    longint       m_int, m_freq, m_jump, m_good;
    logic [31:0]  m_phase;
    bit           m_clk, m_strobe, m_locked;
    longint       win_q[$];
    logic [OUT_W-1:0] exp_q[$];

    function automatic longint clamp32(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_int = 0; m_freq = 0; m_jump = 0; m_good = 0;
        m_phase = '0; m_clk = 0; m_strobe = 0; m_locked = 0;
        win_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input longint e, input logic [31:0] fcw);
        bit upd;
        longint s;
        upd = (m_cnt == 31);
        m_clk = ~m_phase[31];
        m_phase = m_phase + fcw + 32'(m_freq) + (m_strobe ? 32'(m_jump) : 32'd0);
        if (m_strobe) m_jump = 0;
        m_strobe = upd;
        if (v) begin
            win_q.push_back(e);
            m_int = clamp32(m_int + e);
        end
        if (upd) begin
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            m_freq = m_int;
            m_jump = clamp32(s * 8);
            if (s < 64 && s > -64) m_good = m_good + 1;
            else m_good = 0;
            m_locked = (m_good >= 8);
            win_q.delete();
        end
        m_cnt = (m_cnt + 1) % 32;
        exp_q.push_back(m_phase[31:22]);
    endtask

    task automatic check_a();
        chk("phase_out", ifa.phase_out, exp_q.pop_front());
        chk("phase_acc", dut_a.phase_acc, m_phase);
        chk("clk_out", ifa.clk_out, m_clk);
        chk("upd_strobe", ifa.upd_strobe, m_strobe);
        chk("locked", ifa.locked, m_locked);
        chk("sat", ifa.sat, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit v, input logic signed [15:0] d);
        ifa.err_valid = v;
        ifa.err_data  = d;
        @(posedge clk);
        model_step(v, longint'(d), ifa.fcw_init);
        #1 check_a();
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        ifa.err_valid = 1'b0;
        ifa.err_data  = '0;
        model_reset();
        #1;
        chk("rst_phase_out", ifa.phase_out, 0);
        chk("rst_phase_acc", dut_a.phase_acc, 0);
        chk("rst_clk_out", ifa.clk_out, 0);
        chk("rst_upd_strobe", ifa.upd_strobe, 0);
        chk("rst_locked", ifa.locked, 0);
        chk("rst_sat", ifa.sat, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_a = 1'b1;
    endtask

    task automatic align_window();
        while (m_cnt != 0) cycle(0, 16'sd0);
    endtask

    // Idle run straight after reset with fcw = 2**30: fixed clock pattern and strobe cadence.
    task automatic idle_from_reset(input int ncyc);
        int n_str;
        n_str = 0;
        for (int c = 0; c < ncyc; c++) begin
            cycle(0, 16'sd0);
            if (c < 8) chk("clk_pattern", ifa.clk_out, ((c / 2) % 2) == 0);
            chk("strobe_cadence", ifa.upd_strobe, (c % 32) == 31);
            if (ifa.upd_strobe) begin
                n_str++;
                chk("lock_at_strobe", ifa.locked, n_str >= 8);
            end
        end
    endtask

    typedef struct {
        int     n;
        bit     upd_only;
        int     val;
        longint exp_freq;
        longint exp_jump;
        bit     exp_locked;
    } win_vec_t;

    win_vec_t vecs[8];

    initial begin
        logic [19:0] p0, p1, pd;
        int r, spread;
        bit v;

        vecs[0] = '{32, 1'b0,  1,  32,  256, 1'b1};
        vecs[1] = '{ 0, 1'b0,  0,  32,    0, 1'b1};
        vecs[2] = '{32, 1'b0, -1,   0, -256, 1'b1};
        vecs[3] = '{ 1, 1'b1, -5,  -5,  -40, 1'b1};
        vecs[4] = '{ 0, 1'b0,  0,  -5,    0, 1'b1};
        vecs[5] = '{32, 1'b0,  2,  59,  512, 1'b0};
        vecs[6] = '{16, 1'b0, -4,  -5, -512, 1'b0};
        vecs[7] = '{31, 1'b0,  2,  57,  496, 1'b0};

        ifa.fcw_init  = 32'h4000_0000;
        ifa.err_valid = 1'b0;
        ifa.err_data  = '0;
        ifb.fcw_init  = 20'h4_0000;
        ifb.err_valid = 1'b0;
        ifb.err_data  = '0;
        #2;
        rst_b = 1'b0;
        reset_a();

        // Idle loop: clock period 4, strobe every 32, lock at 8th strobe.
        idle_from_reset(8 * 32 + 8);
        align_window();

        // Loop filter windows.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 32; i++) begin
                v = vecs[k].upd_only ? (i == 31) : (i < vecs[k].n);
                cycle(v, 16'(vecs[k].val));
            end
            chk("tbl_strobe", ifa.upd_strobe, 1);
            chk("tbl_freq_adj", dut_a.freq_adj, vecs[k].exp_freq);
            chk("tbl_phase_jump", dut_a.phase_jump, vecs[k].exp_jump);
            chk("tbl_locked", ifa.locked, vecs[k].exp_locked);
        end

        // Re-lock: the last table window was clean, seven more complete eight in a row.
        for (int w = 1; w <= 7; w++) begin
            for (int i = 0; i < 32; i++) cycle(0, 16'sd0);
            chk("relock", ifa.locked, w >= 7);
        end

        // Random error streams, with a mid-run fcw change.
        for (int c = 0; c < 384; c++) begin
            if (c == 200) ifa.fcw_init = 32'h3A00_0000 + $urandom_range(0, 4095);
            spread = ((c / 32) % 3 == 0) ? 40 : 8;
            r = int'($urandom_range(0, 2 * spread)) - spread;
            cycle(1'($urandom_range(0, 1)), 16'(r));
        end

        // Reset in the middle of a busy window.
        ifa.fcw_init = 32'h4000_0000;
        align_window();
        for (int i = 0; i < 13; i++) cycle(1, 16'sd3);
        chk("pre_reset_cnt", m_cnt, 13);
        reset_a();
        idle_from_reset(40);

        // Saturation on the 20-bit instance.
        ifb.err_valid = 1'b1;
        ifb.err_data  = 16'sh7FFF;
        rst_b = 1'b1;
        cycle(0, 16'sd0);
        cycle(0, 16'sd0);
        chk("b_sat_before", ifb.sat, 0);
        cycle(0, 16'sd0);
        chk("b_sat_set", ifb.sat, 1);
        chk("b_int_acc_3", dut_b.int_acc, 98301);
        for (int i = 3; i < 40; i++) cycle(0, 16'sd0);
        chk("b_int_clamp", dut_b.int_acc, 524287);
        chk("b_freq_clamp", dut_b.freq_adj, 524287);
        ifb.err_valid = 1'b0;
        for (int i = 40; i < 80; i++) cycle(0, 16'sd0);
        chk("b_sat_held", ifb.sat, 1);
        p0 = dut_b.phase_acc;
        cycle(0, 16'sd0);
        p1 = dut_b.phase_acc;
        pd = p1 - p0;
        chk("b_phase_wrap_step", pd, 786431);
        rst_b = 1'b0;
        #1 chk("b_sat_cleared", ifb.sat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
